rfphoenix_dcache_repl: RTL

//  Parametrised data-cache replacement and write-way unit for rfPhoenix. Tracks per-set recency,

---
 rtl/rfphoenix_dcache_repl_pkg.sv | 13 +
 rtl/rfphoenix_dcache_repl_plru.sv | 38 +++
 rtl/rfphoenix_dcache_repl.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/rfphoenix_dcache_repl_pkg.sv
// Shared types and constants for the rfPhoenix dcache replacement unit.
package rfphoenix_dcache_repl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PICK  = 2'd1,
        OFFER = 2'd2
    } dcache_repl_state_t;

    // Right-shifting Galois taps for x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [15:0] DCACHE_REPL_LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/rfphoenix_dcache_repl_plru.sv
// Combinational tree pseudo-LRU helper: next tree bits after touching a way, and the
// victim way obtained by walking the tree from the root (0 = lower half).
module rfphoenix_plru_tree #(
    parameter int WAYS = 4
) (
    input  logic [WAYS-2:0]         i_tree,
    input  logic [$clog2(WAYS)-1:0] i_touch,
    output logic [WAYS-2:0]         o_tree,
    output logic [$clog2(WAYS)-1:0] o_victim
);
    localparam int LW = $clog2(WAYS);

    // Heap numbering: node n lives at bit n, bit 0 is unused padding.
    logic [WAYS-1:0] w_ext;
    logic [WAYS-1:0] w_next_ext;
    logic [LW:0]     w_nn;
    logic [LW:0]     w_vn;
    logic            w_unused_ok;

    always_comb begin
        w_ext      = {i_tree, 1'b0};
        w_next_ext = w_ext;
        w_nn       = (LW+1)'(1);
        for (int l = LW - 1; l >= 0; l--) begin
            w_next_ext[w_nn[LW-1:0]] = ~i_touch[l];
            w_nn = {w_nn[LW-1:0], i_touch[l]};
        end
        w_vn = (LW+1)'(1);
        for (int l = LW - 1; l >= 0; l--) begin
            w_vn = {w_vn[LW-1:0], w_ext[w_vn[LW-1:0]]};
        end
    end

    assign o_tree      = w_next_ext[WAYS-1:1];
    assign o_victim    = w_vn[LW-1:0];
    assign w_unused_ok = ^{w_next_ext[0], w_nn[LW], w_vn[LW]};

endmodule

// File: rtl/rfphoenix_dcache_repl.sv
// rfPhoenix dcache victim selection and write-way register. Define RFPHOENIX_DCACHE_PLRU_EN
// for tree pseudo-LRU replacement; otherwise the policy choice comes from the free-running LFSR.
module rfphoenix_dcache_repl
    import rfphoenix_dcache_repl_pkg::*;
#(
    parameter int          WAYS      = 4,
    parameter int          SETS      = 64,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_acc_v,
    input  logic                    i_acc_st,
    input  logic [$clog2(SETS)-1:0] i_acc_set,
    input  logic [$clog2(WAYS)-1:0] i_acc_way,
    input  logic [WAYS-1:0]         i_vld,
    input  logic [WAYS-1:0]         i_lock,
    input  logic                    i_fill_req,
    input  logic [$clog2(SETS)-1:0] i_fill_set,
    output logic                    o_victim_v,
    output logic [$clog2(WAYS)-1:0] o_victim_way,
    output logic                    o_victim_none,
    input  logic                    i_victim_ack,
    output logic [$clog2(WAYS)-1:0] o_wway
);
    localparam int LW = $clog2(WAYS);

    dcache_repl_state_t r_state;
    logic [15:0]        r_lfsr;
    logic               r_victim_v;
    logic [LW-1:0]      r_victim_way;
    logic               r_victim_none;
    logic [LW-1:0]      r_wway;

    logic [15:0]        w_lfsr_next;
    logic [LW-1:0]      w_policy_way;
    logic [LW-1:0]      w_pick_way;
    logic               w_pick_found;
    logic               w_fill_do;

    assign w_lfsr_next = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? DCACHE_REPL_LFSR_TAPS : 16'h0000);
    assign w_fill_do   = (r_state == OFFER) && i_victim_ack && !r_victim_none;

`ifdef RFPHOENIX_DCACHE_PLRU_EN
    logic [WAYS-2:0] r_tree [SETS];
    logic [WAYS-2:0] w_tree_acc;
    logic [WAYS-2:0] w_tree_fill;
    logic [WAYS-2:0] w_fill_base;
    logic [WAYS-2:0] w_read_next_unused;
    logic [LW-1:0]   w_acc_victim_unused;
    logic [LW-1:0]   w_fill_victim_unused;

    // Same-set collision: the fill update is layered on top of the access update.
    assign w_fill_base = (i_acc_v && (i_acc_set == i_fill_set)) ? w_tree_acc : r_tree[i_fill_set];

    rfphoenix_plru_tree #(.WAYS(WAYS)) u_acc (
        .i_tree   (r_tree[i_acc_set]),
        .i_touch  (i_acc_way),
        .o_tree   (w_tree_acc),
        .o_victim (w_acc_victim_unused)
    );

    rfphoenix_plru_tree #(.WAYS(WAYS)) u_fill (
        .i_tree   (w_fill_base),
        .i_touch  (r_victim_way),
        .o_tree   (w_tree_fill),
        .o_victim (w_fill_victim_unused)
    );

    rfphoenix_plru_tree #(.WAYS(WAYS)) u_read (
        .i_tree   (r_tree[i_fill_set]),
        .i_touch  ('0),
        .o_tree   (w_read_next_unused),
        .o_victim (w_policy_way)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int s = 0; s < SETS; s++) begin
                r_tree[s] <= '0;
            end
        end else begin
            if (i_acc_v) begin
                r_tree[i_acc_set] <= w_tree_acc;
            end
            if (w_fill_do) begin
                r_tree[i_fill_set] <= w_tree_fill;
            end
        end
    end
`else
    logic w_unused_ok;

    assign w_policy_way = r_lfsr[LW-1:0];
    assign w_unused_ok  = ^{i_acc_set, i_fill_set, w_fill_do};
`endif

    // Invalid-and-unlocked first, then the policy way, then any unlocked way.
    always_comb begin
        w_pick_way   = '0;
        w_pick_found = 1'b0;
        for (int i = 0; i < WAYS; i++) begin
            if (!w_pick_found && !i_vld[i] && !i_lock[i]) begin
                w_pick_way   = LW'(i);
                w_pick_found = 1'b1;
            end
        end
        if (!w_pick_found && !i_lock[w_policy_way]) begin
            w_pick_way   = w_policy_way;
            w_pick_found = 1'b1;
        end
        for (int i = 0; i < WAYS; i++) begin
            if (!w_pick_found && !i_lock[i]) begin
                w_pick_way   = LW'(i);
                w_pick_found = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= IDLE;
            r_lfsr        <= LFSR_SEED;
            r_victim_v    <= 1'b0;
            r_victim_way  <= '0;
            r_victim_none <= 1'b0;
            r_wway        <= '0;
        end else begin
            r_lfsr <= w_lfsr_next;
            if (i_acc_v && i_acc_st) begin
                r_wway <= i_acc_way;
            end
            case (r_state)
                IDLE: begin
                    if (i_fill_req) begin
                        r_state <= PICK;
                    end
                end
                PICK: begin
                    r_state       <= OFFER;
                    r_victim_v    <= 1'b1;
                    r_victim_way  <= w_pick_found ? w_pick_way : '0;
                    r_victim_none <= !w_pick_found;
                end
                OFFER: begin
                    if (i_victim_ack) begin
                        r_state       <= IDLE;
                        r_victim_v    <= 1'b0;
                        r_victim_none <= 1'b0;
                        if (!r_victim_none) begin
                            r_wway <= r_victim_way;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_victim_v    = r_victim_v;
    assign o_victim_way  = r_victim_way;
    assign o_victim_none = r_victim_none;
    assign o_wway        = r_wway;

endmodule
